// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the BCD-to-segment decoder for the multiplexed 7-segment driver.
package sevenseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DASH  = 8'h40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Active-high {dp,g,f,e,d,c,b,a}; non-decimal codes render blank.
    function automatic seg_t bcd_to_seg(input logic [3:0] digit);
        seg_t pat;
        case (digit)
            4'd0:    pat = 8'h3F;
            4'd1:    pat = 8'h06;
            4'd2:    pat = 8'h5B;
            4'd3:    pat = 8'h4F;
            4'd4:    pat = 8'h66;
            4'd5:    pat = 8'h6D;
            4'd6:    pat = 8'h7D;
            4'd7:    pat = 8'h07;
            4'd8:    pat = 8'h7F;
            4'd9:    pat = 8'h6F;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Bus between the game/dice logic (master) and the scan driver (slave).
interface sevenseg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned VAL_W      = 7
);
    logic [VAL_W-1:0]      value_i;
    logic                  load_i;
    logic                  ready_o;
    logic                  seg_pol_i;
    logic                  com_pol_i;
    logic                  lz_blank_i;
    logic [NUM_DIGITS-1:0] dp_i;
    logic [7:0]            seg_o;
    logic [NUM_DIGITS-1:0] com_o;
    logic                  overflow_o;

    modport master (
        output value_i, load_i, seg_pol_i, com_pol_i, lz_blank_i, dp_i,
        input  ready_o, seg_o, com_o, overflow_o
    );

    modport slave (
        input  value_i, load_i, seg_pol_i, com_pol_i, lz_blank_i, dp_i,
        output ready_o, seg_o, com_o, overflow_o
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift per clock, VAL_W shifts then a one-cycle commit.
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int unsigned VAL_W      = 7,
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [VAL_W-1:0]        i_bin,
    output logic                    o_ready,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_ovf
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    conv_state_t      r_state, w_state_d;
    logic [VAL_W-1:0] r_bin, w_bin_d;
    logic [BCD_W-1:0] r_bcd, w_bcd_d, w_adj;
    logic             r_ovf, w_ovf_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_ready;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Anything shifted out of the top digit means the value needs more digits than we have.
    always_comb begin
        w_state_d = r_state;
        w_bin_d   = r_bin;
        w_bcd_d   = r_bcd;
        w_ovf_d   = r_ovf;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_d = SHIFT;
                    w_bin_d   = i_bin;
                    w_bcd_d   = '0;
                    w_ovf_d   = 1'b0;
                    w_cnt_d   = '0;
                end
            end
            SHIFT: begin
                w_ovf_d = r_ovf | w_adj[BCD_W-1];
                w_bcd_d = {w_adj[BCD_W-2:0], r_bin[VAL_W-1]};
                w_bin_d = r_bin << 1;
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(VAL_W - 1)) begin
                    w_state_d = COMMIT;
                end
            end
            COMMIT: w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_bin   <= w_bin_d;
            r_bcd   <= w_bcd_d;
            r_ovf   <= w_ovf_d;
            r_cnt   <= w_cnt_d;
            r_ready <= (w_state_d == IDLE);
        end
    end

    assign o_ready = r_ready;
    assign o_done  = (r_state == COMMIT);
    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// N-digit multiplexed 7-segment driver: BCD converter, display register, free-running scanner
// with an anti-ghost blank gap, runtime polarity, leading-zero blanking and overflow dashes.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned VAL_W      = 7,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned BLANK_CYC  = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    sevenseg_scan_driver_if.slave io_bus
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;

    logic                  w_start, w_ready, w_done, w_ovf;
    logic [BCD_W-1:0]      w_bcd;
    logic [BCD_W-1:0]      r_disp;
    logic                  r_valid, r_ovf;
    logic [SLOT_W-1:0]     r_slot;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] w_blank_lz, w_com_act;
    logic                  w_nz_above;
    logic [3:0]            w_digit;
    seg_t                  w_pat;
    seg_t                  r_seg;
    logic [NUM_DIGITS-1:0] r_com;

    assign w_start = io_bus.load_i & w_ready;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (io_bus.value_i),
        .o_ready (w_ready),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_done) begin
            r_disp  <= w_bcd;
            r_valid <= 1'b1;
            r_ovf   <= w_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else if (r_slot == SLOT_W'(SCAN_DIV - 1)) begin
            r_slot <= '0;
            r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        w_nz_above = 1'b0;
        w_blank_lz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nz_above    = w_nz_above | (r_disp[4*i +: 4] != 4'd0);
            w_blank_lz[i] = (i != 0) && !w_nz_above;
        end
    end

    always_comb begin
        w_digit   = r_disp[4*r_idx +: 4];
        w_pat     = SEG_BLANK;
        w_com_act = '0;
        if (rst_n && (r_slot >= SLOT_W'(BLANK_CYC))) begin
            if (!r_valid) begin
                w_pat = SEG_BLANK;
            end else if (r_ovf) begin
                w_pat = SEG_DASH;
            end else if (io_bus.lz_blank_i && w_blank_lz[r_idx]) begin
                w_pat = SEG_BLANK;
            end else begin
                w_pat = bcd_to_seg(w_digit);
            end
            w_pat[7]         = w_pat[7] | io_bus.dp_i[r_idx];
            w_com_act[r_idx] = 1'b1;
        end
    end

    // No async reset here: the off level depends on the live polarity inputs, so the
    // outputs settle to "all off" on the first clock while rst_n is held low.
    always_ff @(posedge clk) begin
        r_seg <= io_bus.seg_pol_i ? w_pat : ~w_pat;
        r_com <= io_bus.com_pol_i ? w_com_act : ~w_com_act;
    end

    assign io_bus.seg_o      = r_seg;
    assign io_bus.com_o      = r_com;
    assign io_bus.ready_o    = w_ready;
    assign io_bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: a behavioural model pushes the expected outputs each clock, a monitor pops and compares.
module tb_sevenseg_scan_driver;

    localparam int unsigned ND = 2;
    localparam int unsigned VW = 7;
    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(ND), .VAL_W(VW)) bus ();

    sevenseg_scan_driver #(
        .NUM_DIGITS (ND),
        .VAL_W      (VW),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [7:0]    seg;
        logic [ND-1:0] com;
        logic          ready;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Reference model state: time since reset, converter countdown, shown value.
    int         m_t, m_busy, m_pend, m_val, m_pos, m_idx;
    bit         m_has, m_ovf;
    logic [7:0] m_pat;
    logic [ND-1:0] m_act;
    exp_t       m_e, mon_e;

    function automatic logic [7:0] digit_pat(input int idx);
        int p10;
        p10 = 10 ** idx;
        if (!m_has) return 8'h00;
        if (m_ovf) return 8'h40;
        if (bus.lz_blank_i && idx > 0 && m_val < p10) return 8'h00;
        return seg_tab[(m_val / p10) % 10];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = 0; m_busy = 0; m_has = 1'b0; m_ovf = 1'b0;
            m_e.seg   = bus.seg_pol_i ? 8'h00 : 8'hFF;
            m_e.com   = bus.com_pol_i ? {ND{1'b0}} : {ND{1'b1}};
            m_e.ready = 1'b1;
            m_e.ovf   = 1'b0;
        end else begin
            m_pos = m_t % SD;
            m_idx = (m_t / SD) % ND;
            m_pat = 8'h00;
            m_act = '0;
            if (m_pos >= BC) begin
                m_pat        = digit_pat(m_idx);
                m_pat[7]     = m_pat[7] | bus.dp_i[m_idx];
                m_act[m_idx] = 1'b1;
            end
            m_e.seg = bus.seg_pol_i ? m_pat : ~m_pat;
            m_e.com = bus.com_pol_i ? m_act : ~m_act;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_has = 1'b1;
                    m_val = m_pend;
                    m_ovf = (m_pend >= 10 ** ND);
                end
            end else if (bus.load_i) begin
                m_pend = int'(bus.value_i);
                m_busy = VW + 1;
            end
            m_e.ready = (m_busy == 0);
            m_e.ovf   = m_ovf;
            m_t++;
        end
        exp_q.push_back(m_e);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("seg_o", 32'(bus.seg_o), 32'(mon_e.seg));
                check("com_o", 32'(bus.com_o), 32'(mon_e.com));
                check("ready_o", 32'(bus.ready_o), 32'(mon_e.ready));
                check("overflow_o", 32'(bus.overflow_o), 32'(mon_e.ovf));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        int guard;
        guard = 0;
        while (!bus.ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_wait: got ready_o=0 for %0d cycles, expected 1", guard);
        end
        bus.value_i = VW'(v);
        bus.load_i  = 1'b1;
        @(negedge clk);
        bus.load_i  = 1'b0;
    endtask

    localparam int FRAME = SD * ND;

    initial begin
        bus.value_i    = '0;
        bus.load_i     = 1'b0;
        bus.seg_pol_i  = 1'b1;
        bus.com_pol_i  = 1'b0;
        bus.lz_blank_i = 1'b1;
        bus.dp_i       = '0;
        step(3);
        rst_n = 1'b1;
        step(2 * FRAME);

        do_load(42);
        step(VW + 2 + 2 * FRAME);

        do_load(7);
        step(VW + 2 + FRAME);
        bus.lz_blank_i = 1'b0;
        step(FRAME);
        bus.dp_i = 2'b01;
        step(FRAME);
        bus.dp_i = '0;

        do_load(100);
        step(VW + 2 + FRAME);
        do_load(5);
        step(VW + 2 + FRAME);

        step(3);
        bus.seg_pol_i = 1'b0;
        bus.com_pol_i = 1'b1;
        step(FRAME);
        bus.seg_pol_i = 1'b1;
        bus.com_pol_i = 1'b0;
        step(3);

        do_load(33);
        step(2);
        bus.value_i = VW'(11);
        bus.load_i  = 1'b1;
        step(1);
        bus.load_i  = 1'b0;
        step(VW + 2 + FRAME);

        // Abort a conversion mid-shift; ready must return without waiting for a clock.
        do_load(99);
        step(3);
        #1 rst_n = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.ready_o), 32'd1);
        check("ovf_after_reset", 32'(bus.overflow_o), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(FRAME);

        for (int k = 0; k < 24; k++) begin
            bus.lz_blank_i = 1'($urandom_range(0, 1));
            bus.dp_i       = ND'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.seg_pol_i = ~bus.seg_pol_i;
            if ($urandom_range(0, 3) == 0) bus.com_pol_i = ~bus.com_pol_i;
            do_load(int'($urandom_range(0, 127)));
            if ($urandom_range(0, 1) == 1) begin
                step(int'($urandom_range(1, 6)));
                bus.value_i = VW'($urandom_range(0, 127));
                bus.load_i  = 1'b1;
                step(1);
                bus.load_i  = 1'b0;
            end
            step(int'($urandom_range(VW + 2, VW + 2 + 2 * FRAME)));
        end

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
